// File: rtl/array_sort_check_param.sv
// Register-file-backed sort checker: scans length elements from array, one pair per cycle.
// Optional build macro COUNT_ALL_EN scans the whole array and counts every inversion.
module array_sort_check_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] array,
    input  logic [LEN_W-1:0]  length,
    input  logic              descending,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              sorted,
    output logic [LEN_W-1:0]  inv_index,
    output logic [LEN_W-1:0]  inv_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r, state_s;

    logic [DATA_W-1:0] rf_r [DEPTH];

    logic [ADDR_W-1:0] array_r, array_s;
    logic [LEN_W-1:0]  len_r, len_s;
    logic              desc_r, desc_s;
    logic [LEN_W-1:0]  idx_r, idx_s;
    logic              sorted_r, sorted_s;
    logic [LEN_W-1:0]  inv_index_r, inv_index_s;
    logic [LEN_W-1:0]  inv_count_r, inv_count_s;
    logic              busy_r, done_r;

    logic [LEN_W-1:0]  idx_plus_s;
    logic [ADDR_W-1:0] a_addr_s, b_addr_s;
    logic [DATA_W-1:0] a_s, b_s;
    logic              inv_s;

    // Pair addresses wrap naturally through ADDR_W-bit truncation.
    assign idx_plus_s = idx_r + LEN_ONE;
    assign a_addr_s   = array_r + idx_r[ADDR_W-1:0];
    assign b_addr_s   = a_addr_s + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign a_s        = rf_r[a_addr_s];
    assign b_s        = rf_r[b_addr_s];
    assign inv_s      = desc_r ? (a_s < b_s) : (a_s > b_s);

    // Register file: no reset, writes blocked while a scan is reading it.
    always_ff @(posedge clock) begin
        if (wr_en && (state_r != SCAN)) begin
            rf_r[wr_addr] <= wr_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_s     = state_r;
        array_s     = array_r;
        len_s       = len_r;
        desc_s      = desc_r;
        idx_s       = idx_r;
        sorted_s    = sorted_r;
        inv_index_s = inv_index_r;
        inv_count_s = inv_count_r;
        case (state_r)
            IDLE: begin
                if (go) begin
                    state_s     = SCAN;
                    array_s     = array;
                    len_s       = (length > DEPTH_L) ? DEPTH_L : length;
                    desc_s      = descending;
                    idx_s       = LEN_ZERO;
                    sorted_s    = 1'b0;
                    inv_index_s = LEN_ZERO;
                    inv_count_s = LEN_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (idx_plus_s >= len_r) begin
                    state_s  = DONE;
                    sorted_s = (inv_count_r == LEN_ZERO);
                end else if (inv_s) begin
`ifdef COUNT_ALL_EN
                    if (inv_count_r == LEN_ZERO) begin
                        inv_index_s = idx_r;
                    end else begin
                        inv_index_s = inv_index_r;
                    end
                    inv_count_s = (inv_count_r == CNT_MAX) ? CNT_MAX : (inv_count_r + LEN_ONE);
                    idx_s       = idx_plus_s;
`else
                    inv_index_s = idx_r;
                    inv_count_s = LEN_ONE;
                    sorted_s    = 1'b0;
                    state_s     = DONE;
`endif
                end else begin
                    idx_s = idx_plus_s;
                end
            end
            DONE: begin
                if (go) begin
                    state_s = DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            array_r     <= {ADDR_W{1'b0}};
            len_r       <= LEN_ZERO;
            desc_r      <= 1'b0;
            idx_r       <= LEN_ZERO;
            sorted_r    <= 1'b0;
            inv_index_r <= LEN_ZERO;
            inv_count_r <= LEN_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            array_r     <= array_s;
            len_r       <= len_s;
            desc_r      <= desc_s;
            idx_r       <= idx_s;
            sorted_r    <= sorted_s;
            inv_index_r <= inv_index_s;
            inv_count_r <= inv_count_s;
            busy_r      <= (state_s == SCAN);
            done_r      <= (state_s == DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign sorted    = sorted_r;
    assign inv_index = inv_index_r;
    assign inv_count = inv_count_r;

endmodule
